bram_arbiter: RTL

BRAM_ARBITER -- requirements
Module: bram_arbiter

---
 rtl/bram_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/bram_arbiter.sv
// bram_arbiter: two-requester (DMA, CPU) round-robin arbiter in front of a
// single-port BRAM controller, with per-requester read-outstanding tracking.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   dma_req/wr/addr/wdata    DMA request (held until dma_gnt)
//   dma_gnt                  DMA request accepted this cycle (combinational)
//   cpu_req/wr/addr/wdata    CPU request (held until cpu_gnt)
//   cpu_gnt                  CPU request accepted this cycle (combinational)
//   WR, In_valid, Addr, Di   registered issue to the BRAM controller
//   reader_sel               0 = DMA, 1 = CPU (registered with the issue)
//   dma_in_valid             read data returned to DMA
//   cache_in_valid           read data returned to CPU
//   idle                     nothing outstanding and nothing being issued
//   rsp_err                  sticky: return pulse seen with zero outstanding
module bram_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dma_req,
  input  logic        dma_wr,
  input  logic [12:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [12:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        WR,
  output logic        In_valid,
  output logic [12:0] Addr,
  output logic [31:0] Di,
  output logic        reader_sel,
  input  logic        dma_in_valid,
  input  logic        cache_in_valid,
  output logic        idle,
  output logic        rsp_err
);

  localparam int unsigned AW = 13;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  typedef enum logic {
    SRC_DMA = 1'b0,
    SRC_CPU = 1'b1
  } src_e;

  logic [CW-1:0] r_dma_cnt;
  logic [CW-1:0] r_cpu_cnt;
  src_e          r_last_grant;
  logic          r_in_valid;
  logic          r_wr;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_di;
  src_e          r_sel;
  logic          r_rsp_err;

  logic          w_dma_elig;
  logic          w_cpu_elig;
  logic          w_dma_gnt;
  logic          w_cpu_gnt;
  logic          w_dma_rd;
  logic          w_cpu_rd;
  logic          w_spurious;

  // Saturating outstanding counter: simultaneous issue and return cancel out,
  // a return with nothing outstanding is ignored (and flagged elsewhere).
  function automatic logic [CW-1:0] next_cnt(input logic [CW-1:0] cnt,
                                             input logic inc,
                                             input logic dec);
    logic [CW-1:0] res;
    res = cnt;
    if (inc && !dec) begin
      res = cnt + CW'(1);
    end else if (dec && !inc && (cnt != '0)) begin
      res = cnt - CW'(1);
    end
    return res;
  endfunction

  // Eligibility and round-robin pick; a blocked read never masks the other side.
  always_comb begin
    w_dma_elig = dma_req & (dma_wr | (r_dma_cnt < CW'(MAX_OUTSTANDING)));
    w_cpu_elig = cpu_req & (cpu_wr | (r_cpu_cnt < CW'(MAX_OUTSTANDING)));
    w_dma_gnt  = ~rst & w_dma_elig & (~w_cpu_elig | (r_last_grant == SRC_CPU));
    w_cpu_gnt  = ~rst & w_cpu_elig & ~w_dma_gnt;
    w_dma_rd   = w_dma_gnt & ~dma_wr;
    w_cpu_rd   = w_cpu_gnt & ~cpu_wr;
    w_spurious = (dma_in_valid & (r_dma_cnt == '0)) |
                 (cache_in_valid & (r_cpu_cnt == '0));
  end

  assign dma_gnt = w_dma_gnt;
  assign cpu_gnt = w_cpu_gnt;

  // Issue register: one In_valid pulse per grant, payload held between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_valid   <= 1'b0;
      r_wr         <= 1'b0;
      r_addr       <= '0;
      r_di         <= '0;
      r_sel        <= SRC_DMA;
      r_last_grant <= SRC_CPU;
    end else begin
      r_in_valid <= w_dma_gnt | w_cpu_gnt;
      if (w_dma_gnt) begin
        r_wr         <= dma_wr;
        r_addr       <= dma_addr;
        r_di         <= dma_wdata;
        r_sel        <= SRC_DMA;
        r_last_grant <= SRC_DMA;
      end else if (w_cpu_gnt) begin
        r_wr         <= cpu_wr;
        r_addr       <= cpu_addr;
        r_di         <= cpu_wdata;
        r_sel        <= SRC_CPU;
        r_last_grant <= SRC_CPU;
      end
    end
  end

  // Outstanding read counters and sticky response error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dma_cnt <= '0;
      r_cpu_cnt <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      r_dma_cnt <= next_cnt(r_dma_cnt, w_dma_rd, dma_in_valid);
      r_cpu_cnt <= next_cnt(r_cpu_cnt, w_cpu_rd, cache_in_valid);
      if (w_spurious) begin
        r_rsp_err <= 1'b1;
      end
    end
  end

  assign In_valid   = r_in_valid;
  assign WR         = r_wr;
  assign Addr       = r_addr;
  assign Di         = r_di;
  assign reader_sel = r_sel;
  assign rsp_err    = r_rsp_err;
  assign idle       = (r_dma_cnt == '0) & (r_cpu_cnt == '0) & ~r_in_valid;

endmodule
